// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states, frame limits
// and a width helper. Also intended for the receive-side block.
package uart_pkg;

  // Parity selection as presented on the configuration port.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;

  // Transmitter frame phases.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Longest frame: start + 9 data + parity + 2 stop.
  localparam int UART_MAX_FRAME_BITS = 13;

  // Number of bits needed to hold the value 'value' (minimum 1).
  function automatic int calc_bit_width(input int value);
    int w;
    w = 1;
    while ((w < 31) && ((value >> w) != 0)) w++;
    return w;
  endfunction

  // Width of the per-frame bit counter.
  localparam int BIT_CNT_W = calc_bit_width(UART_MAX_FRAME_BITS);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clocks within one bit and flags the last cycle.
// Held cleared while the transmitter is idle so every frame starts on a
// fresh bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = calc_bit_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // Count 0..CLKS_PER_BIT-1 while running, wrap at each bit boundary.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (!i_run || (baud_cnt == LAST_CNT)) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign o_tick = i_run & (baud_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB first, optional
// even/odd parity, one or two stop bits, valid/ready input with gapless
// back-to-back frames and a done pulse on the last stop-bit cycle.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FRE_CLK  = 100_000_000,
  parameter int UART_BPS = 115200,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_parity,
  input  logic              i_stop2,
  output logic              o_uart_tx,
  output logic              o_uart_busy,
  output logic              o_done
);

  localparam int CLKS_PER_BIT = FRE_CLK / UART_BPS;

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_tx_cfg: CLKS_PER_BIT=%0d is below 4", CLKS_PER_BIT);
  end
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_width
    $error("uart_tx_cfg: DATA_W=%0d outside 5..9", DATA_W);
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_W - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 tick;
  logic                 last_stop;
  logic                 frame_end;
  logic                 transfer;
  parity_e              par_mode;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (busy_q),
    .o_tick (tick)
  );

  // In STOP, bit_idx counts stop bits already sent; the last one is index
  // 0 for one stop bit and index 1 for two.
  assign last_stop = (state_q == STOP) && (bit_idx_q == BIT_CNT_W'(stop2_q));
  assign frame_end = last_stop & tick;
  assign o_ready   = (state_q == IDLE) | frame_end;
  assign transfer  = i_valid & o_ready;
  assign par_mode  = parity_e'(i_parity);

  assign o_uart_tx   = tx_q;
  assign o_uart_busy = busy_q;
  assign o_done      = frame_end;

  // Next-state, shift register, counters and registered line value.
  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    unique case (state_q)
      IDLE: ;
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_DATA_IDX) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (last_stop) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer is only possible in IDLE or on the final stop-bit cycle;
    // either way it overrides the above and launches a new frame.
    if (transfer) begin
      state_d   = START;
      shreg_d   = i_data;
      bit_idx_d = '0;
      par_en_d  = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
      par_bit_d = (par_mode == PAR_ODD) ? ~^i_data : ^i_data;
      stop2_d   = i_stop2;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Frame state register; reset abandons any frame and idles the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule
